// File: rtl/sfq_gate_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sfq_gate_arbiter_if
//  Description : Bundle of requester-side and gate-side signals for the
//                shared SFQ gate arbiter.
//                slave  : arbiter view (drives grants, acks, gate pulses)
//                master : environment view (requesters and gate model)
//  Ports (signals):
//    req, op_a, op_b  [N_REQ]  requests and per-requester operand bits
//    gnt, ack         [N_REQ]  one-hot grant and completion pulse
//    res                       result bit, valid in the ack cycle
//    gate_in1/2, gate_clk      one-cycle pulses toward the gate
//    gate_out                  pulse from the gate output
//    busy, err_spurious, err_multi  status and sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
interface sfq_gate_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] op_a;
  logic [N_REQ-1:0] op_b;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] ack;
  logic             res;
  logic             gate_in1;
  logic             gate_in2;
  logic             gate_clk;
  logic             gate_out;
  logic             busy;
  logic             err_spurious;
  logic             err_multi;

  modport slave (
    input  req, op_a, op_b, gate_out,
    output gnt, ack, res, gate_in1, gate_in2, gate_clk,
           busy, err_spurious, err_multi
  );

  modport master (
    output req, op_a, op_b, gate_out,
    input  gnt, ack, res, gate_in1, gate_in2, gate_clk,
           busy, err_spurious, err_multi
  );
endinterface
`default_nettype wire

// File: rtl/sfq_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sfq_gate_arbiter
//  Description : Round-robin arbiter sharing one clocked SFQ gate between
//                N_REQ requesters. Latches the grantee's operands, pulses
//                the gate data inputs, then the gate clock after T_SETUP
//                cycles, then collects the gate output over a T_RESULT
//                window and returns the result with a one-cycle ack.
//  Ports:
//    clkin  in   system clock, rising edge
//    rst_n  in   asynchronous reset, active low
//    bus    slave modport of sfq_gate_arbiter_if (requests, operands,
//           grant/ack/result, gate pins, busy and error flags)
//  Revision    : 1.0  initial release
// ============================================================================
module sfq_gate_arbiter #(
  parameter int N_REQ    = 4,
  parameter int T_SETUP  = 2,
  parameter int T_RESULT = 3
) (
  input  wire                clkin,
  input  wire                rst_n,
  sfq_gate_arbiter_if.slave  bus
);

  localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_MAX = (T_SETUP > T_RESULT) ? T_SETUP : T_RESULT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_SETUP = 3'd1;
  localparam logic [2:0] c_ST_FIRE  = 3'd2;
  localparam logic [2:0] c_ST_WAIT  = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] c_SETUP_LAST  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] c_RESULT_LAST = CNT_W'(T_RESULT - 1);
  localparam logic [PTR_W-1:0] c_LAST_REQ    = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   c_N_REQ_EXT   = (PTR_W+1)'(N_REQ);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [PTR_W-1:0] r_gidx;
  logic [PTR_W-1:0] r_ptr;
  logic             r_a;
  logic             r_b;
  logic             r_result;
  logic             r_err_spurious;
  logic             r_err_multi;

  // --------------------------------------------------------------------------
  // Round-robin selection: first set req bit at or after r_ptr, wrapping.
  // --------------------------------------------------------------------------
  logic             w_any;
  logic [PTR_W-1:0] w_sel_idx;
  logic [N_REQ-1:0] w_sel_oh;

  always_comb begin
    logic [PTR_W:0] v_idx;
    w_any     = 1'b0;
    w_sel_idx = '0;
    w_sel_oh  = '0;
    v_idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (v_idx >= c_N_REQ_EXT) begin
        v_idx = v_idx - c_N_REQ_EXT;
      end
      if (!w_any && bus.req[v_idx[PTR_W-1:0]]) begin
        w_any     = 1'b1;
        w_sel_idx = v_idx[PTR_W-1:0];
      end
    end
    if (w_any) begin
      w_sel_oh[w_sel_idx] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Transaction sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_ST_IDLE;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_gidx   <= '0;
      r_ptr    <= '0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_result <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_any) begin
            // Operands are captured only here; later input changes are ignored.
            r_gnt    <= w_sel_oh;
            r_gidx   <= w_sel_idx;
            r_a      <= bus.op_a[w_sel_idx];
            r_b      <= bus.op_b[w_sel_idx];
            r_result <= 1'b0;
            r_cnt    <= '0;
            r_state  <= c_ST_SETUP;
          end
        end
        c_ST_SETUP: begin
          if (r_cnt == c_SETUP_LAST) begin
            r_cnt   <= '0;
            r_state <= c_ST_FIRE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_FIRE: begin
          r_cnt   <= '0;
          r_state <= c_ST_WAIT;
        end
        c_ST_WAIT: begin
          if (bus.gate_out) begin
            r_result <= 1'b1;
          end
          if (r_cnt == c_RESULT_LAST) begin
            r_cnt   <= '0;
            r_state <= c_ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_DONE: begin
          r_gnt   <= '0;
          r_ptr   <= (r_gidx == c_LAST_REQ) ? '0 : r_gidx + 1'b1;
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_cnt   <= '0;
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags. Only WAIT is a legal window for gate output pulses;
  // a pulse coincident with the clock pulse (FIRE) is treated as spurious.
  // Every high sample of gate_out counts as one pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_err_spurious <= 1'b0;
      r_err_multi    <= 1'b0;
    end else begin
      if (bus.gate_out && (r_state != c_ST_WAIT)) begin
        r_err_spurious <= 1'b1;
      end
      if (bus.gate_out && (r_state == c_ST_WAIT) && r_result) begin
        r_err_multi <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from registered state, so reset clears them immediately.
  // --------------------------------------------------------------------------
  logic w_in_idle;
  logic w_first_setup;
  logic w_done;

  assign w_in_idle     = (r_state == c_ST_IDLE);
  assign w_first_setup = (r_state == c_ST_SETUP) && (r_cnt == '0);
  assign w_done        = (r_state == c_ST_DONE);

  assign bus.gnt          = r_gnt;
  assign bus.ack          = w_done ? r_gnt : '0;
  assign bus.res          = w_done & r_result;
  assign bus.gate_in1     = w_first_setup & r_a;
  assign bus.gate_in2     = w_first_setup & r_b;
  assign bus.gate_clk     = (r_state == c_ST_FIRE);
  assign bus.busy         = !w_in_idle;
  assign bus.err_spurious = r_err_spurious;
  assign bus.err_multi    = r_err_multi;

endmodule
`default_nettype wire
